// File: rtl/bus_pkg.sv
// Shared definitions for the two-port bus arbiter: FSM encoding, transfer
// modes, port identifiers and the completion-strobe helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    // A transfer finishes only on the strobe that matches its direction;
    // the other strobe is treated as noise.
    function automatic logic is_complete(input logic mode,
                                         input logic rdata_valid,
                                         input logic write_done);
        return (mode == MODE_WRITE) ? write_done : rdata_valid;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// port that was not served last wins.
module rr_pick2
    import bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic gnt
);

    // Pick the winning port from the current requests and the last grant.
    always_comb begin
        valid = req0 | req1;
        gnt   = PORT_IF;
        if (req0 && req1) begin
            gnt = ~last_gnt;
        end else if (req1) begin
            gnt = PORT_MEM;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one BUS_controller between the instruction-fetch port (0) and the
// load/store port (1). One transaction is outstanding at a time; the granted
// port gets a one-cycle done pulse and, for reads, the captured read data.
//
// Handshake: a port raises reqN with modeN/addrN/wdataN stable and holds it
// until it sees doneN, then drops reqN in that same cycle. Toward the bus,
// m_start is a single-cycle pulse with m_mode/m_addr/m_wdata stable from that
// cycle until the matching completion strobe (m_rdata_valid for reads,
// m_write_done for writes) is seen.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  mode0,
    input  logic                  mode1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  m_start,
    output logic                  m_mode,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_rdata_valid,
    input  logic                  m_write_done,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output state_t                dbg_state
);

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  m_mode_q, m_mode_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic pick_valid;
    logic pick_gnt;
    logic complete;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .gnt      (pick_gnt)
    );

    assign complete = (state_q == ST_WAIT) &&
                      is_complete(m_mode_q, m_rdata_valid, m_write_done);

    // State and datapath registers; reset leaves port 0 winning the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= PORT_IF;
            last_gnt_q <= PORT_MEM;
            m_mode_q   <= MODE_READ;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            m_mode_q   <= m_mode_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Next-state: requests are only looked at in IDLE, never in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (complete) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's request at grant; capture read data at completion.
    always_comb begin
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        m_mode_d   = m_mode_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        if (state_q == ST_IDLE && pick_valid) begin
            gnt_d = pick_gnt;
            if (pick_gnt == PORT_MEM) begin
                m_mode_d  = mode1;
                m_addr_d  = addr1;
                m_wdata_d = wdata1;
            end else begin
                m_mode_d  = mode0;
                m_addr_d  = addr0;
                m_wdata_d = wdata0;
            end
        end
        if (complete) begin
            last_gnt_d = gnt_q;
            if (m_mode_q == MODE_READ) begin
                if (gnt_q == PORT_MEM) begin
                    rdata1_d = m_rdata;
                end else begin
                    rdata0_d = m_rdata;
                end
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        m_start = (state_q == ST_ISSUE);
        busy    = (state_q != ST_IDLE);
        done0   = (state_q == ST_DONE) && (gnt_q == PORT_IF);
        done1   = (state_q == ST_DONE) && (gnt_q == PORT_MEM);
    end

    assign m_mode    = m_mode_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-port arbiter that shares the single BUS_controller between the CPU instruction-fetch port (port 0) and the load/store port (port 1).
- Each requester issues a held request. The arbiter picks one round-robin, drives BUS_controller's start_transaction/mode/addr/wdata, and waits for rdata_valid or write_done.
- It returns a registered done pulse and read data to the granted requester only.
- Sits between the CPU core and BUS_controller.

Parameters:
- DATA_WIDTH, 32, data bus width; must match BUS_controller.
- ADDR_WIDTH, 32, address bus width; must match BUS_controller.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  request from port 0 / port 1; held high until that port's done
- mode0 / mode1  in  1  0 read, 1 write; stable while req high
- addr0 / addr1  in  ADDR_WIDTH  request address; stable while req high
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req high
- done0 / done1  out  1  one-cycle completion pulse to port 0 / port 1
- rdata0 / rdata1  out  DATA_WIDTH  read data, valid when the matching done pulses with mode=0; holds until that port's next read completes
- busy  out  1  high in any state other than IDLE
- m_start  out  1  to BUS_controller start_transaction
- m_mode  out  1  to BUS_controller mode
- m_addr  out  ADDR_WIDTH  to BUS_controller addr
- m_wdata  out  DATA_WIDTH  to BUS_controller wdata
- m_rdata_valid  in  1  from BUS_controller rdata_valid
- m_write_done  in  1  from BUS_controller write_done
- m_rdata  in  DATA_WIDTH  from BUS_controller rdata

Behaviour:
- Reset: all outputs 0; state IDLE; gnt=0; last_gnt=1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req0|req1, choose a port. Single request: grant it. Both: grant !last_gnt.
  - Register gnt and latch that port's mode/addr/wdata into m_mode/m_addr/m_wdata; go ISSUE.
  - Otherwise stay.
- ISSUE:
  - m_start=1 for exactly this cycle, with m_mode/m_addr/m_wdata stable; go WAIT.
- WAIT:
  - m_start=0; m_mode/m_addr/m_wdata are held.
  - Read (m_mode=0): completes on m_rdata_valid; capture m_rdata into rdata[gnt].
  - Write (m_mode=1): completes on m_write_done.
  - On completion, set last_gnt=gnt and go DONE.
  - Completion strobe of the wrong kind for m_mode is ignored.
- DONE:
  - done[gnt]=1 for one cycle; the other done stays 0; go IDLE.
  - Requests are not sampled in DONE.
  - The requester must drop req in the cycle it sees done. A req still high in the following IDLE cycle is a new request.
- Latency:
  - req sampled at edge N → m_start high in cycle N+1 → done at completion edge +1.
  - Minimum 3 arbiter cycles plus BUS_controller latency.
- Back-to-back: if both ports request continuously, grants alternate 0,1,0,1.
- Fairness: the losing port is always served next; maximum wait is one transaction.
- Request withdrawn after grant: illegal. The arbiter completes the transaction and still pulses done.
- Only one transaction is outstanding; m_start never asserts outside ISSUE.
- Reset mid-operation: immediately return to reset values. No done is produced. BUS_controller shares rst_n and also resets.

Decomposition:
- Shared package bus_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3
  - MODE_READ=1'b0, MODE_WRITE=1'b1
  - PORT_IF=1'b0, PORT_MEM=1'b1
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin picker (req0, req1, last_gnt → valid, gnt).
- The FSM, latches and response registers stay in bus_arbiter.

Test Plan:
- Reset with req0=req1=1 held → all outputs 0 during reset. After release, first grant is port 0 (m_addr=addr0) and m_start is high for exactly 1 cycle.
- Port 0 read, addr0=0x100, stubbed bus returns 0xDEADBEEF with m_rdata_valid 2 cycles after m_start → done0 pulses one cycle later with rdata0=0xDEADBEEF; done1=0; rdata1 unchanged.
- Port 1 write, addr1=0x200, wdata1=0x12345678, mode1=1 → m_mode=1, m_wdata=0x12345678 at m_start; done1 one cycle after m_write_done; rdata1 unchanged.
- req0 and req1 held continuously for 6 transactions → grant order 0,1,0,1,0,1; m_start never asserted while busy in WAIT.
- Spurious m_write_done during a read in WAIT → ignored; completion only on m_rdata_valid.
- rst_n asserted in WAIT → immediate return to IDLE, busy=0, no done pulse. After release, a new req1 is served normally.
